sobel_frame_loader: RTL



---
 rtl/sobel_pkg.sv | 19 +
 rtl/sobel_frame_loader_raster_counter.sv | 46 ++++
 rtl/sobel_frame_loader.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types and address layout for the Sobel core and its frame loader.
// The {row, col} packing here must match the core's read addressing.
package sobel_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

  localparam int IMG_W_DEF = 512;
  localparam int IMG_H_DEF = 512;
  localparam int PIX_W_DEF = 8;
  localparam int COL_W_DEF = 9;
  localparam int ROW_W_DEF = 9;

  function automatic logic [31:0] pack_addr(input logic [15:0] row,
                                            input logic [15:0] col,
                                            input int unsigned col_w);
    return (32'(row) << col_w) | 32'(col);
  endfunction

endpackage

// File: rtl/sobel_frame_loader_raster_counter.sv
// Raster col/row position tracker; updates on the edge a beat is consumed.
// No backpressure of its own: the caller qualifies step/restart with the handshake.
module raster_counter import sobel_pkg::*; #(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int COL_W = COL_W_DEF,
  parameter int ROW_W = ROW_W_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             restart,
  input  logic             step,
  input  logic             tlast,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last_pix,
  output logic             line_err
);

  logic eol;
  logic last_row;

  assign eol      = (col == COL_W'(IMG_W - 1));
  assign last_row = (row == ROW_W'(IMG_H - 1));
  assign last_pix = last_row & eol;
  // A line is malformed when tlast and the column limit disagree.
  assign line_err = step & (tlast != eol);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      col <= '0;
      row <= '0;
    end else if (restart) begin
      col <= COL_W'(1);
      row <= '0;
    end else if (step) begin
      if (tlast || eol) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sobel_frame_loader.sv
// Loads one raster frame into the core's input BRAM, then runs the core via ap_start/ap_done.
// Writes land one cycle after acceptance; s_tready drops from the last pixel until ap_done.
module sobel_frame_loader import sobel_pkg::*; #(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int COL_W = COL_W_DEF,
  parameter int ROW_W = ROW_W_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [PIX_W-1:0]       s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   s_tuser,
  input  logic                   s_tlast,
  output logic [ROW_W+COL_W-1:0] mem_address0,
  output logic                   mem_ce0,
  output logic                   mem_we0,
  output logic [PIX_W-1:0]       mem_d0,
  output logic                   core_start,
  input  logic                   core_done,
  output logic                   frame_done,
  output logic                   err_line,
  output logic                   err_sof,
  output logic [15:0]            frame_cnt
);

  localparam int ADDR_W = ROW_W + COL_W;

  state_t             state;
  logic               tready_q;
  logic               acc;
  logic               restart;
  logic               step;
  logic               wr_vld;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COL_W-1:0]   col_cnt;
  logic [ROW_W-1:0]   row_cnt;
  logic               last_pix;
  logic               line_err;

  assign s_tready = tready_q;
  // tready is only high in IDLE/LOAD, so acc already implies one of those states.
  assign acc      = s_tvalid & tready_q;
  assign restart  = acc & s_tuser;
  assign step     = acc & ~s_tuser & (state == LOAD);
  assign wr_vld   = restart | step;
  assign wr_addr  = restart ? '0
                            : ADDR_W'(pack_addr(16'(row_cnt), 16'(col_cnt), COL_W));

  raster_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .COL_W(COL_W),
    .ROW_W(ROW_W)
  ) u_raster (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .restart (restart),
    .step    (step),
    .tlast   (s_tlast),
    .col     (col_cnt),
    .row     (row_cnt),
    .last_pix(last_pix),
    .line_err(line_err)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state        <= IDLE;
      tready_q     <= 1'b0;
      mem_ce0      <= 1'b0;
      mem_we0      <= 1'b0;
      mem_address0 <= '0;
      mem_d0       <= '0;
      core_start   <= 1'b0;
      frame_done   <= 1'b0;
      err_line     <= 1'b0;
      err_sof      <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      mem_ce0    <= wr_vld;
      mem_we0    <= wr_vld;
      frame_done <= 1'b0;
      if (wr_vld) begin
        mem_address0 <= wr_addr;
        mem_d0       <= s_tdata;
      end
      case (state)
        IDLE: begin
          tready_q <= 1'b1;
          if (restart) state <= LOAD;
        end
        LOAD: begin
          if (restart) begin
            err_sof <= 1'b1;
          end else if (step) begin
            if (line_err) err_line <= 1'b1;
            if (last_pix) begin
              state    <= FLUSH;
              tready_q <= 1'b0;
            end
          end
        end
        FLUSH: begin
          state      <= RUN;
          core_start <= 1'b1;
        end
        RUN: begin
          if (core_done) begin
            core_start <= 1'b0;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
            tready_q   <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
